// File: rtl/edge_event_detector.sv
// Multi-channel input conditioner: synchroniser, optional debounce (EDGE_DETECT_DEBOUNCE_EN),
// registered rising/falling pulses, sticky per-channel event flags and an aggregate irq.
module edge_event_detector #(
    parameter int CHANNELS        = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [CHANNELS-1:0] signal,
    input  logic [CHANNELS-1:0] rise_en,
    input  logic [CHANNELS-1:0] fall_en,
    input  logic [CHANNELS-1:0] event_clr,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rising_edge,
    output logic [CHANNELS-1:0] falling_edge,
    output logic [CHANNELS-1:0] event_pending,
    output logic                irq
);

    if (CHANNELS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("edge_event_detector: illegal parameter combination");
    end

    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
    logic [CHANNELS-1:0] r_level;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic [CHANNELS-1:0] r_pending;
    logic                r_irq;

    logic [CHANNELS-1:0] w_s;
    logic [CHANNELS-1:0] w_level_next;
    logic [CHANNELS-1:0] w_rise_next;
    logic [CHANNELS-1:0] w_fall_next;
    logic [CHANNELS-1:0] w_pending_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int st = 0; st < SYNC_STAGES; st++) begin
                r_sync[st] <= '0;
            end
        end else begin
            r_sync[0] <= signal;
            for (int st = 1; st < SYNC_STAGES; st++) begin
                r_sync[st] <= r_sync[st-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

`ifdef EDGE_DETECT_DEBOUNCE_EN
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt      [CHANNELS];
    logic [CNT_W-1:0] w_cnt_next [CHANNELS];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_level_next = r_level;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_cnt_next[ch] = '0;
            if (w_s[ch] != r_level[ch]) begin
                if (r_cnt[ch] == CNT_LAST) begin
                    w_level_next[ch] = w_s[ch];
                end else begin
                    w_cnt_next[ch] = r_cnt[ch] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_cnt[ch] <= '0;
            end
        end else begin
            r_cnt <= w_cnt_next;
        end
    end
`else
    always_comb begin
        w_level_next = w_s;
    end
`endif

    // Edges and flags are derived from the next level so they appear in the same cycle as it.
    always_comb begin
        w_rise_next    = w_level_next & ~r_level;
        w_fall_next    = ~w_level_next & r_level;
        w_pending_next = (w_rise_next & rise_en) | (w_fall_next & fall_en)
                       | (r_pending & ~event_clr);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_level   <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_pending <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_level   <= w_level_next;
            r_rise    <= w_rise_next;
            r_fall    <= w_fall_next;
            r_pending <= w_pending_next;
            r_irq     <= |w_pending_next;
        end
    end

    assign level         = r_level;
    assign rising_edge   = r_rise;
    assign falling_edge  = r_fall;
    assign event_pending = r_pending;
    assign irq           = r_irq;

endmodule
